// File: rtl/regwrite_trace_tx.sv
// regwrite_trace_tx: captures CPU register-file writes into a small FIFO and
// streams each one out as a five-byte UART 8N1 frame on a single trace pin.
// Byte order: {3'b101, WriteReg}, then Result bytes least significant first.
// Optional feature macro: TRACE_FILTER_X0_EN (when defined, writes to x0 are
// neither captured nor counted as overflow).
module regwrite_trace_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        RegWrite,
  input  logic [4:0]                  WriteReg,
  input  logic [31:0]                 Result,
  output logic                        tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK   = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, next_state;
  logic [36:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [39:0]   frame;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx, byte_idx;
  logic          capture, pop, push, bit_done, tx_next;

  // Decide whether this edge's write strobe is a traceable event
  always_comb begin
`ifdef TRACE_FILTER_X0_EN
    capture = RegWrite && (WriteReg != 5'd0);
`else
    capture = RegWrite;
`endif
  end

  // A pop frees a slot on the same edge, so a full FIFO can still accept
  assign bit_done = (clk_cnt == LAST_CLK);
  assign pop      = (state == IDLE) && (fifo_count != '0);
  assign push     = capture && ((fifo_count < FULL_COUNT) || pop);

  // FIFO storage; no reset needed since only occupied slots are ever read
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= {WriteReg, Result};
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
      if (capture && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Transmitter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Transmitter next-state logic; bytes follow each other with no gap
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fifo_count != '0) next_state = START;
      START:   if (bit_done) next_state = DATA;
      DATA:    if (bit_done && (bit_idx == 3'd7)) next_state = STOP;
      STOP:    if (bit_done) next_state = (byte_idx < 3'd4) ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Line level wanted for the current bit period
  always_comb begin
    tx_next = 1'b1;
    case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = frame[{byte_idx, bit_idx}];
      default: tx_next = 1'b1;
    endcase
  end

  // Frame register and bit/byte/clock counters
  always_ff @(posedge clk) begin
    if (reset) begin
      frame    <= '0;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      if ((state == IDLE) || bit_done) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            frame    <= {mem[rd_ptr][31:0], 3'b101, mem[rd_ptr][36:32]};
            byte_idx <= '0;
            bit_idx  <= '0;
          end
        end
        START:   bit_idx <= '0;
        DATA:    if (bit_done) bit_idx <= bit_idx + 1'b1;
        STOP:    if (bit_done && (byte_idx < 3'd4)) byte_idx <= byte_idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Registered line and busy flag so the pin never glitches
  always_ff @(posedge clk) begin
    if (reset) begin
      tx   <= 1'b1;
      busy <= 1'b0;
    end else begin
      tx   <= tx_next;
      busy <= (state != IDLE) || (fifo_count != '0);
    end
  end

endmodule

// File: tb/tb_regwrite_trace_tx.sv
// tb_regwrite_trace_tx: scoreboard bench for regwrite_trace_tx with a
// queue-based reference model and a cycle-sampled UART receiver.
`timescale 1ns/1ps
module tb_regwrite_trace_tx;

  localparam int C     = 4;
  localparam int D     = 8;
  localparam int CNT_W = $clog2(D) + 1;

  typedef struct {
    logic [7:0] data;
    int         start_edge;
  } exp_t;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             reg_write = 1'b0;
  logic [4:0]       write_reg = '0;
  logic [31:0]      result    = '0;
  logic             tx, busy, overflow;
  logic [CNT_W-1:0] fifo_count;

  exp_t        exp_q[$];
  logic [36:0] model_q[$];
  logic [7:0]  rx_log[$];
  int          rx_start_log[$];
  int          edge_no    = 0;
  int          next_pop   = 0;
  logic        ovf_exp    = 1'b0;
  int          errors     = 0;
  int          checks     = 0;
  logic        rx_active  = 1'b0;
  int          rx_cnt     = 0;
  int          rx_start   = 0;
  int          rx_starts  = 0;
  int          peak_count = 0;
  logic [7:0]  rx_byte    = '0;

  regwrite_trace_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .RegWrite   (reg_write),
    .WriteReg   (write_reg),
    .Result     (result),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] r, input logic [31:0] d);
    reg_write = we;
    write_reg = r;
    result    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleCycles(2);
    reset = 1'b0;
    peak_count = 0;
    rx_log.delete();
    rx_start_log.delete();
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while ((model_q.size() != 0 || exp_q.size() != 0 || rx_active) && n < bound) begin
      applyStimulus(1'b0, 5'd0, 32'd0);
      n++;
    end
    checkOutput("drain_done", (model_q.size() == 0 && exp_q.size() == 0 && !rx_active), 1);
    idleCycles(2 * C + 2);
    checkOutput("busy_after_drain", busy, 0);
    checkOutput("tx_idle_after_drain", tx, 1);
  endtask

  function automatic logic [7:0] frameByte(input logic [36:0] ev, input int k);
    logic [31:0] d = ev[31:0];
    if (k == 0) return {3'b101, ev[36:32]};
    return d[8*(k-1) +: 8];
  endfunction

  function automatic logic [8:0] getLog(input int k);
    if (k < rx_log.size()) return {1'b0, rx_log[k]};
    return 9'h1FF;
  endfunction

  function automatic int getStart(input int k);
    if (k < rx_start_log.size()) return rx_start_log[k];
    return -1000;
  endfunction

  // Reference model: FIFO as a queue, transmitter as "free again 50*C+1 edges after a pop"
  always @(posedge clk) begin : model
    int          pre;
    bit          do_pop, req;
    logic [36:0] ev;
    edge_no++;
    if (reset) begin
      model_q.delete();
      exp_q.delete();
      ovf_exp  = 1'b0;
      next_pop = 0;
    end else begin
      pre    = model_q.size();
      do_pop = (edge_no >= next_pop) && (pre > 0);
`ifdef TRACE_FILTER_X0_EN
      req = reg_write && (write_reg != 5'd0);
`else
      req = reg_write;
`endif
      if (do_pop) begin
        ev = model_q.pop_front();
        for (int k = 0; k < 5; k++)
          exp_q.push_back('{data: frameByte(ev, k), start_edge: edge_no + 1 + 10 * C * k});
        next_pop = edge_no + 50 * C + 1;
      end
      if (req) begin
        if (pre < D || do_pop) model_q.push_back({write_reg, result});
        else ovf_exp = 1'b1;
      end
    end
  end

  // Monitor: per-cycle status compare plus UART decode against the scoreboard
  always @(negedge clk) begin : monitor
    int   idx;
    exp_t e;
    if (edge_no > 0) begin
      checkOutput("fifo_count", fifo_count, model_q.size());
      checkOutput("overflow", overflow, ovf_exp);
      if (int'(fifo_count) > peak_count) peak_count = int'(fifo_count);
    end
    if (reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        rx_start  = edge_no;
        rx_byte   = '0;
        rx_starts++;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == C / 2) begin
        checkOutput("start_bit", tx, 0);
      end else if (rx_cnt >= C + C / 2 && rx_cnt <= 8 * C + C / 2 && ((rx_cnt - C / 2) % C) == 0) begin
        idx = (rx_cnt - C - C / 2) / C;
        rx_byte[idx] = tx;
      end else if (rx_cnt == 9 * C + C / 2) begin
        checkOutput("stop_bit", tx, 1);
        rx_log.push_back(rx_byte);
        rx_start_log.push_back(rx_start);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_byte: actual=0x%0h expected=none", rx_byte);
        end else begin
          e = exp_q.pop_front();
          checkOutput("byte_data", rx_byte, e.data);
          checkOutput("byte_start_edge", rx_start, e.start_edge);
        end
        rx_active = 1'b0;
      end
    end
  end

  // Directed scenarios followed by a randomized burst phase
  initial begin
    int cap;
    int starts;
    int n;

    reset = 1'b1; reg_write = 1'b1; write_reg = 5'd9; result = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; reg_write = 1'b0;
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_fifo_count", fifo_count, 0);
    checkOutput("reset_overflow", overflow, 0);

    $display("[TB] single write x2=7");
    rx_log.delete(); rx_start_log.delete();
    applyStimulus(1'b1, 5'd2, 32'h7);
    cap = edge_no;
    idleCycles(50);
    checkOutput("busy_mid_frame", busy, 1);
    waitDrain(400);
    checkOutput("t1_nbytes", rx_log.size(), 5);
    checkOutput("t1_byte0", getLog(0), 9'h0A2);
    checkOutput("t1_byte1", getLog(1), 9'h007);
    checkOutput("t1_byte2", getLog(2), 9'h000);
    checkOutput("t1_byte4", getLog(4), 9'h000);
    checkOutput("t1_latency", getStart(0) - cap, 2);
    checkOutput("t1_frame_span", getStart(4) - getStart(0), 40 * C);

    $display("[TB] ten back-to-back writes");
    doReset();
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 5'(i), 32'(i));
    applyStimulus(1'b0, 5'd0, 32'd0);
    checkOutput("t2_overflow", overflow, 1);
    checkOutput("t2_peak_count", peak_count, D);
    waitDrain(9 * (50 * C + 1) + 100);
    checkOutput("t2_nbytes", rx_log.size(), 45);
    checkOutput("t2_first_reg", getLog(0), 9'h0A1);
    checkOutput("t2_last_reg", getLog(40), 9'h0A9);
    checkOutput("t2_last_data", getLog(41), 9'h009);
    checkOutput("t2_frame_gap", getStart(5) - getStart(0), 50 * C + 1);

    $display("[TB] push on the pop edge of a full FIFO");
    doReset();
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 5'(i + 10), $urandom);
    n = 0;
    while (edge_no + 1 < next_pop && n < 1000) begin
      applyStimulus(1'b0, 5'd0, 32'd0);
      n++;
    end
    checkOutput("t3_full_before", fifo_count, D);
    applyStimulus(1'b1, 5'd31, 32'hCAFEF00D);
    checkOutput("t3_count_stays", fifo_count, D);
    checkOutput("t3_no_overflow", overflow, 0);
    waitDrain(10 * (50 * C + 1) + 100);
    checkOutput("t3_last_reg", getLog(45), 9'h0BF);

    $display("[TB] reset mid-frame");
    doReset();
    for (int i = 5; i <= 8; i++) applyStimulus(1'b1, 5'(i), $urandom);
    idleCycles(20);
    checkOutput("t4_queued", fifo_count, 3);
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0);
    reset = 1'b0;
    checkOutput("t4_tx_after_reset", tx, 1);
    checkOutput("t4_count_after_reset", fifo_count, 0);
    checkOutput("t4_ovf_after_reset", overflow, 0);
    checkOutput("t4_busy_after_reset", busy, 0);
    starts = rx_starts;
    idleCycles(300);
    checkOutput("t4_no_more_frames", rx_starts, starts);
    checkOutput("t4_tx_idle", tx, 1);

    $display("[TB] x0 handling");
    doReset();
    applyStimulus(1'b1, 5'd0, 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd3, 32'h12345678);
    waitDrain(700);
`ifdef TRACE_FILTER_X0_EN
    checkOutput("t5_nbytes", rx_log.size(), 5);
    checkOutput("t5_byte0", getLog(0), 9'h0A3);
    checkOutput("t5_byte1", getLog(1), 9'h078);
    checkOutput("t5_byte4", getLog(4), 9'h012);
`else
    checkOutput("t5_nbytes", rx_log.size(), 10);
    checkOutput("t5_byte0", getLog(0), 9'h0A0);
    checkOutput("t5_byte1", getLog(1), 9'h0EF);
    checkOutput("t5_byte4", getLog(4), 9'h0DE);
    checkOutput("t5_byte5", getLog(5), 9'h0A3);
`endif

    $display("[TB] random bursts");
    doReset();
    for (int t = 0; t < 2500; t++) begin
      if ($urandom_range(0, 99) < 4) begin
        n = $urandom_range(1, 12);
        for (int b = 0; b < n; b++) applyStimulus(1'b1, 5'($urandom_range(0, 31)), $urandom);
      end else begin
        applyStimulus(1'b0, 5'd0, 32'd0);
      end
    end
    waitDrain(D * (50 * C + 1) + 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
